// File: rtl/rv32i_arb_pkg.sv
// Shared encodings and defaults for the rv32i fetch/data memory arbiter.
package rv32i_arb_pkg;

  localparam int unsigned DEF_MAX_DATA_STREAK = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/rv32i_arb_prio.sv
// Winner select (data-over-fetch) with a saturating data-streak counter
// that hands the next contested grant to fetch once the streak limit is hit.
module rv32i_arb_prio
  import rv32i_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
  input  logic clk,
  input  logic rst,
  input  logic if_pend_i,
  input  logic d_pend_i,
  input  logic take_i,
  output logic pick_fetch_o
);

  localparam int unsigned SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  logic [SW-1:0] streak_q, streak_d;

  always_comb begin
    pick_fetch_o = if_pend_i & (~d_pend_i | (streak_q == STREAK_MAX));
  end

  always_comb begin
    streak_d = streak_q;
    if (take_i) begin
      if (pick_fetch_o || !if_pend_i) begin
        streak_d = '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
// Optional perf counters are enabled with `define RV32I_ARB_PERF_EN.
module rv32i_mem_arbiter
  import rv32i_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = DEF_MAX_DATA_STREAK,
  parameter int unsigned ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
`ifdef RV32I_ARB_PERF_EN
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_stall_cycles,
`endif
  output logic              err
);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              we_q, we_d;
  logic              err_q, err_d;

  logic if_pend, take, pick_fetch, rsp;

  assign if_pend = if_req & fetch_en;
  // Arbitration happens in IDLE and in the WAIT cycle that completes the transaction.
  assign take = (if_pend | d_req) &
                ((state_q == IDLE) | ((state_q == WAIT) & mem_rvalid));
  assign rsp  = (state_q == WAIT) & mem_rvalid;

  rv32i_arb_prio #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_prio (
    .clk         (clk),
    .rst         (rst),
    .if_pend_i   (if_pend),
    .d_pend_i    (d_req),
    .take_i      (take),
    .pick_fetch_o(pick_fetch)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    err_d   = err_q | (mem_rvalid & (state_q != WAIT));
    case (state_q)
      IDLE:    if (take) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (mem_rvalid) begin
          state_d = take ? ISSUE : IDLE;
          owner_d = NONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      owner_d = pick_fetch ? FETCH : DATA;
      addr_d  = pick_fetch ? if_addr : d_addr;
      wdata_d = pick_fetch ? '0 : d_wdata;
      be_d    = pick_fetch ? 4'hF : d_be;
      we_d    = pick_fetch ? 1'b0 : d_we;
    end
  end

  always_comb begin
    mem_req   = (state_q == ISSUE);
    mem_we    = mem_req ? we_q : 1'b0;
    mem_be    = mem_req ? be_q : '0;
    mem_addr  = mem_req ? addr_q : '0;
    mem_wdata = mem_req ? wdata_q : '0;
    if_gnt    = mem_req & (owner_q == FETCH);
    d_gnt     = mem_req & (owner_q == DATA);
    if_rvalid = rsp & (owner_q == FETCH);
    d_rvalid  = rsp & (owner_q == DATA);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
    err       = err_q;
  end

`ifdef RV32I_ARB_PERF_EN
  logic [31:0] pif_q, pd_q, pst_q;
  logic        stall;

  assign stall = (if_pend & ~if_gnt) | (d_req & ~d_gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      pif_q <= '0;
      pd_q  <= '0;
      pst_q <= '0;
    end else begin
      pif_q <= pif_q + {31'd0, if_gnt};
      pd_q  <= pd_q + {31'd0, d_gnt};
      pst_q <= pst_q + {31'd0, stall};
    end
  end

  assign perf_if_grants    = pif_q;
  assign perf_d_grants     = pd_q;
  assign perf_stall_cycles = pst_q;
`endif

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Scoreboard bench for rv32i_mem_arbiter with a fixed-latency memory model.
module tb_rv32i_mem_arbiter;

  typedef struct packed {
    logic        fetch;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst, fetch_en, if_req, d_req, d_we, mem_rvalid;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, err;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
`ifdef RV32I_ARB_PERF_EN
  logic [31:0] perf_if_grants, perf_d_grants, perf_stall_cycles;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned mem_lat = 2;
  int unsigned spur_cnt = 0;
  int unsigned spur_done;
  rsp_t        rsp_q[$];
  logic        gnt_q[$];

  rv32i_mem_arbiter #(
    .MAX_DATA_STREAK(4),
    .ADDR_W         (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_en  (fetch_en),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
`ifdef RV32I_ARB_PERF_EN
    .perf_if_grants   (perf_if_grants),
    .perf_d_grants    (perf_d_grants),
    .perf_stall_cycles(perf_stall_cycles),
`endif
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h10) ? 32'h0010_0093 : (a ^ 32'hC0DE_0000);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int unsigned n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input logic fetch, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (fetch ? if_gnt : d_gnt) seen = 1'b1;
    end
    if (!seen) check_eq(tag, 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (rsp_q.size() != 0 || gnt_q.size() != 0); i++) @(negedge clk);
    check_eq("drain_leftover", 64'(rsp_q.size() + gnt_q.size()), 64'd0);
    tick();
  endtask

  // Memory: responds mem_lat cycles after the mem_req cycle; writes return 0.
  initial begin
    int unsigned lat;
    logic [31:0] cap_addr;
    logic        cap_we;
    lat = 0;
    cap_addr = '0;
    cap_we = 1'b0;
    spur_done = 0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        lat = 0;
      end else if (mem_req) begin
        lat = mem_lat;
        cap_addr = mem_addr;
        cap_we = mem_we;
      end
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = cap_we ? 32'h0 : mem_data(cap_addr);
        end
      end else if (spur_cnt != spur_done) begin
        spur_done++;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hBAD0_0001;
      end
    end
  end

  // Monitor: grants and responses popped against the scoreboard queues.
  initial begin
    logic g;
    rsp_t e;
    forever begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin
        if (gnt_q.size() == 0) begin
          check_eq("gnt_unexpected", {62'd0, if_gnt, d_gnt}, 64'd0);
        end else begin
          g = gnt_q.pop_front();
          check_eq("gnt_owner", {62'd0, if_gnt, d_gnt}, g ? 64'd2 : 64'd1);
        end
      end
      if (if_rvalid || d_rvalid) begin
        if (rsp_q.size() == 0) begin
          check_eq("rsp_unexpected", {62'd0, if_rvalid, d_rvalid}, 64'd0);
        end else begin
          e = rsp_q.pop_front();
          check_eq("rsp_owner", {62'd0, if_rvalid, d_rvalid}, e.fetch ? 64'd2 : 64'd1);
          check_eq("rsp_data", {32'd0, if_rvalid ? if_rdata : d_rdata}, {32'd0, e.data});
          check_eq("rsp_other_zero", {32'd0, if_rvalid ? d_rdata : if_rdata}, 64'd0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int unsigned n;
    logic f;
    rst = 1'b1; fetch_en = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;

    do_reset(2);
    @(negedge clk);
    check_eq("reset_ctrl", {57'd0, mem_req, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid, err}, 64'd0);
    check_eq("reset_bus", {mem_addr, mem_wdata}, 64'd0);
    check_eq("reset_data", {if_rdata, d_rdata}, 64'd0);

    // Single fetch
    tick();
    fetch_en = 1'b1; if_req = 1'b1; if_addr = 32'h10;
    gnt_q.push_back(1'b1);
    rsp_q.push_back(rsp_t'({1'b1, 32'h0010_0093}));
    @(negedge clk);
    check_eq("fetch_no_early_gnt", {62'd0, if_gnt, mem_req}, 64'd0);
    @(negedge clk);
    check_eq("fetch_gnt_latency", {61'd0, if_gnt, mem_req, mem_we}, 64'b110);
    check_eq("fetch_mem_fields", {mem_addr, 28'd0, mem_be}, {32'h10, 32'hF});
    tick();
    if_req = 1'b0;
    drain();

    // Store
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    gnt_q.push_back(1'b0);
    rsp_q.push_back(rsp_t'({1'b0, 32'h0}));
    wait_gnt(1'b0, "store_gnt_timeout");
    check_eq("store_ctrl", {58'd0, mem_req, mem_we, mem_be}, 64'b11_0011);
    check_eq("store_addr_data", {mem_addr, mem_wdata}, {32'h100, 32'hDEAD_BEEF});
    tick();
    d_req = 1'b0; d_we = 1'b0;
    drain();

    // Contention: four data grants then one fetch grant, repeating
    for (int i = 0; i < 11; i++) begin
      f = (i == 4 || i == 9);
      gnt_q.push_back(f);
      rsp_q.push_back(rsp_t'({f, mem_data(f ? 32'h200 : 32'h300)}));
    end
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h300;
    n = 0;
    for (int c = 0; c < 300 && n < 11; c++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) n++;
    end
    check_eq("contention_grants", 64'(n), 64'd11);
    tick();
    if_req = 1'b0; d_req = 1'b0;
    drain();

    // fetch_en masks fetch requests
    fetch_en = 1'b0; if_req = 1'b1; if_addr = 32'h40;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("fetch_en0_blocked", {62'd0, if_gnt, mem_req}, 64'd0);
    end
    tick();
    fetch_en = 1'b1;
    gnt_q.push_back(1'b1);
    rsp_q.push_back(rsp_t'({1'b1, mem_data(32'h40)}));
    @(negedge clk);
    @(negedge clk);
    check_eq("fetch_en1_gnt", {63'd0, if_gnt}, 64'd1);
    tick();
    if_req = 1'b0;
    drain();

    // Spurious response while idle
    @(negedge clk);
    spur_cnt++;
    @(negedge clk);
    check_eq("spur_not_routed", {62'd0, if_rvalid, d_rvalid}, 64'd0);
    @(negedge clk);
    check_eq("spur_err_set", {63'd0, err}, 64'd1);
    repeat (3) @(negedge clk);
    check_eq("spur_err_sticky", {63'd0, err}, 64'd1);
    tick();
    do_reset(1);
    @(negedge clk);
    check_eq("spur_err_cleared", {63'd0, err}, 64'd0);

    // Reset while waiting on memory
    mem_lat = 5;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h400;
    gnt_q.push_back(1'b0);
    wait_gnt(1'b0, "rstwait_gnt_timeout");
    tick();
    d_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstwait_ctrl", {57'd0, mem_req, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid, err}, 64'd0);
    check_eq("rstwait_bus", {mem_addr, 28'd0, mem_be}, 64'd0);
    mem_lat = 2;
    tick();
    d_req = 1'b1; d_addr = 32'h500;
    gnt_q.push_back(1'b0);
    rsp_q.push_back(rsp_t'({1'b0, mem_data(32'h500)}));
    wait_gnt(1'b0, "post_rst_gnt_timeout");
    tick();
    d_req = 1'b0;
    drain();
    check_eq("final_err", {63'd0, err}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
